// File: rtl/mux_scan.sv
// ============================================================================
// mux_scan : registered N:1 channel mux with manual select and dwell-timed scan
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module mux_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 3,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    output logic                      wrap,
    output logic                      sel_err
);

    localparam int               SLOTS     = 1 << SEL_W;
    localparam logic [SEL_W-1:0] C_LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [7:0]       C_LAST_DW = 8'(DWELL - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [7:0]       r_dcnt;

    logic [WIDTH-1:0] w_slot [SLOTS];
    logic             w_sel_ok;
    logic             w_advance;
    logic [SEL_W-1:0] w_ptr_next;

    // Pad the channel table to a power of two so any sel value indexes safely.
    generate
        for (genvar k = 0; k < SLOTS; k++) begin : g_slot
            if (k < CHANNELS) begin : g_live
                assign w_slot[k] = in_bus[k*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_slot[k] = '0;
            end
        end
    endgenerate

    assign w_sel_ok   = (sel <= C_LAST_CH);
    assign w_advance  = (r_dcnt == C_LAST_DW);
    assign w_ptr_next = (r_ptr == C_LAST_CH) ? '0 : r_ptr + SEL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_dcnt    <= '0;
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            sel_err   <= 1'b0;
        end else if (!en) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_dcnt    <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            sel_err   <= 1'b0;
        end else if (!mode) begin
            r_state <= ST_MANUAL;
            r_ptr   <= '0;
            r_dcnt  <= '0;
            wrap    <= 1'b0;
            out_ch  <= sel;
            if (w_sel_ok) begin
                out       <= w_slot[sel];
                out_valid <= 1'b1;
                sel_err   <= 1'b0;
            end else begin
                out       <= '0;
                out_valid <= 1'b0;
                sel_err   <= 1'b1;
            end
        end else begin
            r_state   <= ST_SCAN;
            out_valid <= 1'b1;
            sel_err   <= 1'b0;
            // The entry edge itself samples channel 0 and counts as dwell cycle 0.
            if (r_state != ST_SCAN) begin
                r_ptr  <= '0;
                r_dcnt <= '0;
                out    <= w_slot[0];
                out_ch <= '0;
                wrap   <= 1'b0;
            end else if (w_advance) begin
                r_ptr  <= w_ptr_next;
                r_dcnt <= '0;
                out    <= w_slot[w_ptr_next];
                out_ch <= w_ptr_next;
                wrap   <= (r_ptr == C_LAST_CH);
            end else begin
                r_dcnt <= r_dcnt + 8'd1;
                out    <= w_slot[r_ptr];
                out_ch <= r_ptr;
                wrap   <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter WIDTH, default 8, data width of each channel in bits (1..32).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Parameter DWELL, default 3, clock cycles spent on each channel in scan mode (1..255).
REQ-004 Derived constant SEL_W = max(1, ceil(log2(CHANNELS))); not overridable.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_bus  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  channel select in manual mode.
REQ-009 mode  input  1  0 = manual, 1 = round-robin scan.
REQ-010 en  input  1  block enable; 0 forces IDLE.
REQ-011 out  output  WIDTH  registered selected data.
REQ-012 out_ch  output  SEL_W  channel index that produced the current out.
REQ-013 out_valid  output  1  out/out_ch hold a legal channel sample this cycle.
REQ-014 wrap  output  1  one-cycle pulse when scan pointer wraps CHANNELS-1 -> 0.
REQ-015 sel_err  output  1  high while manual mode is active with sel >= CHANNELS.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, MANUAL, SCAN.
REQ-017 Transitions, evaluated every edge: en=0 -> IDLE; en=1 & mode=0 -> MANUAL; en=1 & mode=1 -> SCAN.
REQ-018 IDLE: out and out_ch hold last values; out_valid=0; wrap=0; sel_err=0.
REQ-019 MANUAL: out <= in_bus[sel], out_ch <= sel, out_valid <= 1, one cycle latency from sel/in_bus to out.
REQ-020 MANUAL with sel >= CHANNELS: out <= 0, out_ch <= sel, out_valid <= 0, sel_err <= 1.
REQ-021 SCAN: internal pointer ptr (SEL_W bits) and dwell counter dcnt (8 bits) SHALL be used; out <= in_bus[ptr], out_ch <= ptr, out_valid <= 1 every cycle.
REQ-022 Entering SCAN from any other state SHALL set ptr=0, dcnt=0 on that edge; first scanned sample is channel 0.
REQ-023 In SCAN, dcnt increments each cycle; when dcnt=DWELL-1, dcnt <= 0 and ptr advances.
REQ-024 ptr advance: ptr=CHANNELS-1 -> 0 with wrap=1 for exactly that cycle; otherwise ptr+1, wrap=0; ptr SHALL never hold a value >= CHANNELS.
REQ-025 DWELL=1: ptr SHALL advance every cycle; each channel sampled for exactly one cycle.
REQ-026 Leaving SCAN (mode 1->0 or en 1->0) mid-dwell SHALL discard ptr/dcnt; re-entry restarts per REQ-022.
REQ-027 Changes to sel while in SCAN SHALL have no effect; mode/en changes take effect on the next edge.
REQ-028 in_bus is sampled, not held: out reflects in_bus value at the capturing edge.

Reset
REQ-029 rst=1 SHALL asynchronously force: state=IDLE, out=0, out_ch=0, out_valid=0, wrap=0, sel_err=0, ptr=0, dcnt=0.
REQ-030 Reset asserted mid-scan SHALL clear all state immediately without waiting for clk; first edge after release with en=1 behaves as fresh entry.

Verification
REQ-031 Defaults, en=1, mode=0, in_bus=0x44_33_22_11, sel stepped 0..3 one per cycle -> out=0x11,0x22,0x33,0x44 each one cycle after sel, out_valid=1.
REQ-032 CHANNELS=3, mode=0, sel=3 -> out=0, out_valid=0, sel_err=1; sel=1 next -> sel_err=0, out=channel 1.
REQ-033 Defaults, mode=1 for 14 cycles -> out_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0,0; wrap=1 only on first cycle of second channel-0 period.
REQ-034 DWELL=1, CHANNELS=4, scan 8 cycles -> out_ch 0,1,2,3,0,1,2,3; wrap=1 at cycles 5 only within window.
REQ-035 Scan at out_ch=2 mid-dwell, mode->0 for 2 cycles then ->1 -> scan restarts at out_ch=0 with full 3-cycle dwell.
REQ-036 rst pulsed between clock edges during scan -> out=0, out_valid=0, out_ch=0 immediately; en=0 -> out holds, out_valid=0.
